// File: rtl/wb_stage_buf.sv
// Elastic DEPTH-entry writeback buffer between MEM and the register-file write port.
// Valid/ready on both sides, global rdy freeze, synchronous flush and a forwarding query.
module wb_stage_buf #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_wen,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_wen,
  output logic [CNT_W-1:0]  occupancy,
  input  logic [ADDR_W-1:0] q_addr,
  output logic              q_hit,
  output logic [DATA_W-1:0] q_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic              wen_mem  [DEPTH];

  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic             push, pop;
  logic             fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  // No pass-through: a full buffer refuses even when the head pops this cycle,
  // which keeps out_ready off the in_ready path.
  assign in_ready  = rdy & ~rst & (count != FULL);
  assign out_valid = rdy & ~rst & (count != '0);
  assign out_data  = rst ? '0 : data_mem[head];
  assign out_addr  = rst ? '0 : addr_mem[head];
  assign out_wen   = rst ? 1'b0 : wen_mem[head];
  assign occupancy = rst ? '0 : count;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // NOTE: non-blocking assignments here so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      // NOTE: storage is explicitly zeroed on reset so the head outputs read 0 afterwards.
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        addr_mem[i] <= '0;
        wen_mem[i]  <= 1'b0;
      end
    end else if (rdy) begin
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) begin
          data_mem[tail] <= in_data;
          addr_mem[tail] <= in_addr;
          wen_mem[tail]  <= in_wen & (in_addr != '0);
          tail           <= tail + PTR_W'(1);
        end
        if (pop) begin
          head <= head + PTR_W'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Scan from oldest to youngest so the last match wins.
  always_comb begin
    // NOTE: defaults first so no path through the loop leaves a latch behind.
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] idx;
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && wen_mem[idx] && (addr_mem[idx] == q_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[idx];
      end
    end
  end

  assign q_hit  = ~rst & (q_addr != '0) & fwd_hit;
  assign q_data = q_hit ? fwd_data : '0;

endmodule

// File: tb/tb_wb_stage_buf.sv
// Directed bench for wb_stage_buf (DEPTH = 2): per-cycle vector table plus a streaming sequence.
module tb_wb_stage_buf;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int NVEC   = 29;

  logic              clk = 1'b0;
  logic              rst, rdy, flush;
  logic              in_valid, in_ready;
  logic [DATA_W-1:0] in_data;
  logic [ADDR_W-1:0] in_addr;
  logic              in_wen;
  logic              out_valid, out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_wen;
  logic [CNT_W-1:0]  occupancy;
  logic [ADDR_W-1:0] q_addr;
  logic              q_hit;
  logic [DATA_W-1:0] q_data;

  int tests = 0;
  int fails = 0;

  wb_stage_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_addr(in_addr), .in_wen(in_wen),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .out_wen(out_wen), .occupancy(occupancy),
    .q_addr(q_addr), .q_hit(q_hit), .q_data(q_data)
  );

  always #5 clk = ~clk;

  // Inputs applied for one cycle, and the outputs expected just before the next edge.
  typedef struct {
    int rst, rdy, flush, iv, idata, iaddr, iwen, ordy, qaddr;
    int chk_out, e_ir, e_ov, e_od, e_oa, e_ow, e_occ, e_qh, e_qd;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst       = v.rst[0];
    rdy       = v.rdy[0];
    flush     = v.flush[0];
    in_valid  = v.iv[0];
    in_data   = DATA_W'(v.idata);
    in_addr   = ADDR_W'(v.iaddr);
    in_wen    = v.iwen[0];
    out_ready = v.ordy[0];
    q_addr    = ADDR_W'(v.qaddr);
  endtask

  initial begin
    //          rst rdy fl iv data     addr wen ordy q |chk ir ov od       oa ow occ qh qd
    vecs[0]  = '{1, 1, 0, 1, 'h55,    4,  1, 0, 4,   1, 0, 0, 0,       0, 0, 0, 0, 0};
    vecs[1]  = '{0, 1, 0, 1, 'h11,    3,  1, 1, 0,   0, 1, 0, 0,       0, 0, 0, 0, 0};
    vecs[2]  = '{0, 1, 0, 1, 'h22,    4,  1, 1, 3,   1, 1, 1, 'h11,    3, 1, 1, 1, 'h11};
    vecs[3]  = '{0, 1, 0, 1, 'h33,    5,  1, 1, 4,   1, 1, 1, 'h22,    4, 1, 1, 1, 'h22};
    vecs[4]  = '{0, 1, 0, 0, 0,       0,  0, 1, 3,   1, 1, 1, 'h33,    5, 1, 1, 0, 0};
    vecs[5]  = '{0, 1, 0, 1, 'h55,    5,  1, 0, 0,   0, 1, 0, 0,       0, 0, 0, 0, 0};
    vecs[6]  = '{0, 1, 0, 1, 'h66,    6,  1, 0, 5,   1, 1, 1, 'h55,    5, 1, 1, 1, 'h55};
    vecs[7]  = '{0, 1, 0, 1, 'h77,    7,  1, 0, 6,   1, 0, 1, 'h55,    5, 1, 2, 1, 'h66};
    vecs[8]  = '{0, 1, 0, 1, 'h77,    7,  1, 1, 5,   1, 0, 1, 'h55,    5, 1, 2, 1, 'h55};
    vecs[9]  = '{0, 1, 0, 0, 0,       0,  0, 1, 0,   1, 1, 1, 'h66,    6, 1, 1, 0, 0};
    vecs[10] = '{0, 1, 0, 1, 'hDEAD,  0,  1, 0, 0,   0, 1, 0, 0,       0, 0, 0, 0, 0};
    vecs[11] = '{0, 1, 0, 0, 0,       0,  0, 1, 0,   1, 1, 1, 'hDEAD,  0, 0, 1, 0, 0};
    vecs[12] = '{0, 1, 0, 1, 'hA,     7,  1, 0, 7,   0, 1, 0, 0,       0, 0, 0, 0, 0};
    vecs[13] = '{0, 1, 0, 1, 'hB,     7,  1, 0, 7,   1, 1, 1, 'hA,     7, 1, 1, 1, 'hA};
    vecs[14] = '{0, 1, 0, 0, 0,       0,  0, 0, 7,   1, 0, 1, 'hA,     7, 1, 2, 1, 'hB};
    vecs[15] = '{0, 0, 0, 1, 'hC,     8,  1, 1, 7,   0, 0, 0, 0,       0, 0, 2, 1, 'hB};
    vecs[16] = '{0, 0, 0, 1, 'hC,     8,  1, 1, 7,   0, 0, 0, 0,       0, 0, 2, 1, 'hB};
    vecs[17] = '{0, 0, 0, 1, 'hC,     8,  1, 1, 7,   0, 0, 0, 0,       0, 0, 2, 1, 'hB};
    vecs[18] = '{0, 1, 0, 0, 0,       0,  0, 1, 7,   1, 0, 1, 'hA,     7, 1, 2, 1, 'hB};
    vecs[19] = '{0, 1, 0, 0, 0,       0,  0, 1, 7,   1, 1, 1, 'hB,     7, 1, 1, 1, 'hB};
    vecs[20] = '{0, 1, 0, 0, 0,       0,  0, 0, 7,   0, 1, 0, 0,       0, 0, 0, 0, 0};
    vecs[21] = '{0, 1, 0, 1, 'h21,    9,  1, 0, 9,   0, 1, 0, 0,       0, 0, 0, 0, 0};
    vecs[22] = '{0, 1, 1, 1, 'h22,    10, 1, 1, 10,  1, 1, 1, 'h21,    9, 1, 1, 0, 0};
    vecs[23] = '{0, 1, 0, 0, 0,       0,  0, 0, 10,  0, 1, 0, 0,       0, 0, 0, 0, 0};
    vecs[24] = '{0, 1, 0, 1, 'h24,    11, 1, 0, 10,  0, 1, 0, 0,       0, 0, 0, 0, 0};
    vecs[25] = '{0, 1, 0, 0, 0,       0,  0, 0, 11,  1, 1, 1, 'h24,   11, 1, 1, 1, 'h24};
    vecs[26] = '{0, 1, 0, 1, 'h26,    12, 1, 0, 11,  1, 1, 1, 'h24,   11, 1, 1, 1, 'h24};
    vecs[27] = '{1, 1, 0, 1, 'h27,    13, 1, 1, 12,  1, 0, 0, 0,       0, 0, 0, 0, 0};
    vecs[28] = '{0, 1, 0, 0, 0,       0,  0, 0, 12,  1, 1, 0, 0,       0, 0, 0, 0, 0};

    drive(vecs[0]);
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d in_ready", i),  32'(in_ready),  32'(vecs[i].e_ir));
      check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      check($sformatf("v%0d occupancy", i), 32'(occupancy), 32'(vecs[i].e_occ));
      check($sformatf("v%0d q_hit", i),     32'(q_hit),     32'(vecs[i].e_qh));
      check($sformatf("v%0d q_data", i),    q_data,         32'(vecs[i].e_qd));
      if (vecs[i].chk_out != 0) begin
        check($sformatf("v%0d out_data", i), out_data,      32'(vecs[i].e_od));
        check($sformatf("v%0d out_addr", i), 32'(out_addr), 32'(vecs[i].e_oa));
        check($sformatf("v%0d out_wen", i),  32'(out_wen),  32'(vecs[i].e_ow));
      end
      @(posedge clk);
      #1;
    end

    // Back-to-back stream from empty: one entry per cycle in and out.
    flush     = 1'b0;
    rst       = 1'b0;
    rdy       = 1'b1;
    out_ready = 1'b1;
    q_addr    = '0;
    for (int k = 0; k < 9; k++) begin
      in_valid = (k < 8);
      in_data  = 32'h100 + 32'(k);
      in_addr  = ADDR_W'(k % 7 + 1);
      in_wen   = 1'b1;
      #1;
      check($sformatf("s%0d in_ready", k),  32'(in_ready),  32'd1);
      check($sformatf("s%0d out_valid", k), 32'(out_valid), (k > 0) ? 32'd1 : 32'd0);
      if (k > 0) begin
        check($sformatf("s%0d out_data", k), out_data, 32'h100 + 32'(k - 1));
        check($sformatf("s%0d occupancy", k), 32'(occupancy), 32'd1);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    #1;
    check("s_end occupancy", 32'(occupancy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
